// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared ALU,
// with request/ready handshakes to instruction and data memory.
module mips_multi_cycle #(
    parameter int          N        = 32,
    parameter int          ADDR_W   = 16,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IM_REQ,
    output logic [N-1:0]      IM_ADDR,
    input  logic              IM_RDY,
    input  logic [31:0]       INSTRUCTION,
    output logic              DM_REQ,
    output logic              DM_WE,
    output logic [ADDR_W-1:0] DM_ADDR,
    output logic [N-1:0]      DM_D,
    input  logic [N-1:0]      DM_Q,
    input  logic              DM_RDY,
    output logic              HALTED
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    state_t         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [31:0]    ir_q, ir_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [N-1:0]   rf_q [0:31];

    logic [5:0]     opcode_s, funct_s;
    logic [4:0]     rs_s, rt_s, rd_s, shamt_s;
    logic [N-1:0]   simm_s, pc_plus4_s, br_target_s, j_target_s, alu_s;
    logic           legal_s, is_jr_s;
    logic           rf_we_s;
    logic [4:0]     rf_waddr_s;
    logic [N-1:0]   rf_wdata_s;

    assign opcode_s    = ir_q[31:26];
    assign rs_s        = ir_q[25:21];
    assign rt_s        = ir_q[20:16];
    assign rd_s        = ir_q[15:11];
    assign shamt_s     = ir_q[10:6];
    assign funct_s     = ir_q[5:0];
    assign simm_s      = {{(N-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_plus4_s  = pc_q + N'(3'd4);
    assign br_target_s = pc_plus4_s + {simm_s[N-3:0], 2'b00};
    assign j_target_s  = {pc_plus4_s[N-1:28], ir_q[25:0], 2'b00};
    assign is_jr_s     = (opcode_s == OP_RTYPE) && (funct_s == FN_JR);

    // Instruction legality decode
    always_comb begin
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR: legal_s = 1'b1;
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: legal_s = 1'b1;
            default: legal_s = 1'b0;
        endcase
    end

    // Shared ALU: R-type operations, otherwise base + sign-extended immediate
    always_comb begin
        alu_s = a_q + simm_s;
        if (opcode_s == OP_RTYPE) begin
            case (funct_s)
                FN_ADD:  alu_s = a_q + b_q;
                FN_SUB:  alu_s = a_q - b_q;
                FN_AND:  alu_s = a_q & b_q;
                FN_OR:   alu_s = a_q | b_q;
                FN_SLT:  alu_s = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                FN_SLL:  alu_s = b_q << shamt_s;
                FN_SRL:  alu_s = b_q >> shamt_s;
                default: alu_s = a_q + b_q;
            endcase
        end else begin
            alu_s = a_q + simm_s;
        end
    end

    // Next-state and datapath control; architectural state moves only on completed steps
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = alu_q;
        case (state_q)
            S_FETCH: begin
                if (IM_RDY) begin
                    ir_d    = INSTRUCTION;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rs_s];
                b_d = rf_q[rt_s];
                if (!legal_s) begin
                    state_d = S_HALT;
                end else if ((opcode_s == OP_J) || (opcode_s == OP_JAL)) begin
                    pc_d       = j_target_s;
                    rf_we_s    = (opcode_s == OP_JAL);
                    rf_waddr_s = 5'd31;
                    rf_wdata_s = pc_plus4_s;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_s;
                if (opcode_s == OP_BEQ) begin
                    pc_d    = (a_q == b_q) ? br_target_s : pc_plus4_s;
                    state_d = S_FETCH;
                end else if (is_jr_s) begin
                    pc_d    = a_q;
                    state_d = S_FETCH;
                end else if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (!DM_RDY) begin
                    state_d = S_MEM;
                end else if (opcode_s == OP_LW) begin
                    mdr_d   = DM_Q;
                    state_d = S_WB;
                end else begin
                    pc_d    = pc_plus4_s;
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
                rf_wdata_s = (opcode_s == OP_LW) ? mdr_q : alu_q;
                pc_d       = pc_plus4_s;
                state_d    = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // State, datapath registers and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            if (rf_we_s && (rf_waddr_s != 5'd0)) begin
                rf_q[rf_waddr_s] <= rf_wdata_s;
            end
        end
    end

    assign IM_REQ  = (state_q == S_FETCH);
    assign IM_ADDR = pc_q;
    assign DM_REQ  = (state_q == S_MEM);
    assign DM_WE   = (state_q == S_MEM) && (opcode_s == OP_SW);
    assign DM_ADDR = alu_q[ADDR_W-1:0];
    assign DM_D    = b_q;
    assign HALTED  = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Bench for mips_multi_cycle: wait-state memory models, vector table, directed
// multi-cycle sequences and random programs against an instruction-level model.
module tb_mips_multi_cycle;
    localparam int N      = 32;
    localparam int ADDR_W = 16;
    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;
    localparam int OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_ADDI = 8, OP_LW = 35, OP_SW = 43;
    localparam int FN_SLL = 0, FN_SRL = 2, FN_JR = 8, FN_ADD = 32, FN_SUB = 34;
    localparam int FN_AND = 36, FN_OR = 37, FN_SLT = 42;

    logic clk, rst;
    logic im_req, im_rdy, dm_req, dm_we, dm_rdy, halted;
    logic [N-1:0] im_addr, dm_d, dm_q;
    logic [31:0] instruction;
    logic [ADDR_W-1:0] dm_addr;

    mips_multi_cycle #(.N(N), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .IM_REQ(im_req), .IM_ADDR(im_addr), .IM_RDY(im_rdy), .INSTRUCTION(instruction),
        .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_D(dm_d),
        .DM_Q(dm_q), .DM_RDY(dm_rdy), .HALTED(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [0:255];
    logic [31:0] dinit [0:255];
    logic [31:0] dst [0:255];
    logic [255:0] dst_vld;
    logic mem_clr = 1'b0;
    int im_wait = 0, dm_wait = 0;
    int im_cnt, dm_cnt, cyc, halt_cyc, n_stores, overlap, dm_run_len;
    logic [31:0] fetch_cyc[$], fetch_addr[$], dm_runs[$], acc_addr[$], acc_data[$];
    logic dm_unstable, prev_req;
    logic [ADDR_W-1:0] prev_addr;
    logic [N-1:0] prev_d;
    int n_cmp = 0, n_fail = 0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_mem [0:255];
    int m_halt_cyc, m_fetches;

    assign im_rdy      = im_req && (im_cnt >= im_wait);
    assign instruction = (im_addr < 32'd1024) ? imem[im_addr[9:2]] : ILLEGAL;
    assign dm_rdy      = dm_req && (dm_cnt >= dm_wait);
    assign dm_q        = dst_vld[dm_addr[9:2]] ? dst[dm_addr[9:2]] : dinit[dm_addr[9:2]];

    // Wait-state counters and bus monitors
    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0; halt_cyc <= -1; im_cnt <= 0; dm_cnt <= 0; dm_run_len <= 0;
            prev_req <= 1'b0; dm_unstable <= 1'b0;
            fetch_cyc.delete(); fetch_addr.delete(); dm_runs.delete();
            acc_addr.delete(); acc_data.delete();
        end else begin
            cyc    <= cyc + 1;
            im_cnt <= (im_req && !im_rdy) ? im_cnt + 1 : 0;
            dm_cnt <= (dm_req && !dm_rdy) ? dm_cnt + 1 : 0;
            if (halted && halt_cyc < 0) halt_cyc <= cyc;
            if (im_req && im_rdy) begin
                fetch_cyc.push_back(cyc);
                fetch_addr.push_back(im_addr);
            end
            if (im_req && dm_req) overlap <= overlap + 1;
            if (dm_req && prev_req && (dm_addr != prev_addr || dm_d != prev_d)) dm_unstable <= 1'b1;
            prev_req <= dm_req; prev_addr <= dm_addr; prev_d <= dm_d;
            if (dm_req && dm_rdy) begin
                dm_runs.push_back(dm_run_len + 1);
                acc_addr.push_back(32'(dm_addr));
                acc_data.push_back(dm_d);
                dm_run_len <= 0;
            end else if (dm_req) begin
                dm_run_len <= dm_run_len + 1;
            end else begin
                dm_run_len <= 0;
            end
        end
    end

    // Data RAM store side
    always @(posedge clk) begin
        if (mem_clr) begin
            dst_vld <= '0;
        end else if (!rst && dm_req && dm_rdy && dm_we) begin
            dst[dm_addr[9:2]]     <= dm_d;
            dst_vld[dm_addr[9:2]] <= 1'b1;
            n_stores              <= n_stores + 1;
        end
    end

    function automatic logic [31:0] mem_rd(input int i);
        return dst_vld[i] ? dst[i] : dinit[i];
    endfunction

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_type(input int op, input logic [25:0] t);
        return {6'(op), t};
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic begin_load();
        rst = 1'b1;
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i]  = ILLEGAL;
            dinit[i] = 32'h0;
        end
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!halted) begin
            n_fail++;
            $display("FAIL %s_timeout: no halt after %0d cycles, required halt", name, budget);
        end
        @(negedge clk);
    endtask

    // Instruction-level reference: executes imem from PC 0 and accumulates cycle costs
    task automatic model_run(input int iw, input int dw);
        logic [31:0] pc, npc, ins, a, b, simm, res, ea;
        int rs, rt, rd, cost;
        bit done, wr;
        int wreg;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        for (int i = 0; i < 256; i++) m_mem[i] = dinit[i];
        pc = 32'h0; m_fetches = 0; m_halt_cyc = 0; done = 1'b0;
        for (int step = 0; step < 2000 && !done; step++) begin
            ins = (pc < 32'd1024) ? imem[pc[9:2]] : ILLEGAL;
            m_fetches++;
            rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
            a = m_regs[rs]; b = m_regs[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea = a + simm;
            npc = pc + 32'd4; wr = 1'b0; wreg = 0; res = 32'h0; cost = 4;
            case (int'(ins[31:26]))
                0: begin
                    wr = 1'b1; wreg = rd;
                    case (int'(ins[5:0]))
                        FN_ADD: res = a + b;
                        FN_SUB: res = a - b;
                        FN_AND: res = a & b;
                        FN_OR:  res = a | b;
                        FN_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        FN_SLL: res = b << ins[10:6];
                        FN_SRL: res = b >> ins[10:6];
                        FN_JR:  begin wr = 1'b0; npc = a; cost = 3; end
                        default: done = 1'b1;
                    endcase
                end
                OP_ADDI: begin wr = 1'b1; wreg = rt; res = ea; end
                OP_LW:   begin wr = 1'b1; wreg = rt; res = m_mem[ea[9:2]]; cost = 5 + dw; end
                OP_SW:   begin m_mem[ea[9:2]] = b; cost = 4 + dw; end
                OP_BEQ:  begin cost = 3; if (a == b) npc = pc + 32'd4 + (simm << 2); end
                OP_J:    begin cost = 2; npc = {npc[31:28], ins[25:0], 2'b00}; end
                OP_JAL:  begin cost = 2; wr = 1'b1; wreg = 31; res = pc + 32'd4;
                               npc = {npc[31:28], ins[25:0], 2'b00}; end
                default: done = 1'b1;
            endcase
            if (done) begin
                m_halt_cyc += iw + 2;
            end else begin
                if (wr && wreg != 0) m_regs[wreg] = res;
                m_halt_cyc += cost + iw;
                pc = npc;
            end
        end
    endtask

    function automatic logic [31:0] rand_instr(input int i, input int nb);
        int k, rs, rt, rd, fn, sh, off;
        k  = $urandom_range(0, 11);
        rs = $urandom_range(1, 7); rt = $urandom_range(1, 7); rd = $urandom_range(0, 7);
        sh = 0;
        case ($urandom_range(0, 6))
            0: fn = FN_ADD; 1: fn = FN_SUB; 2: fn = FN_AND; 3: fn = FN_OR;
            4: fn = FN_SLT; 5: begin fn = FN_SLL; sh = $urandom_range(0, 31); end
            default: begin fn = FN_SRL; sh = $urandom_range(0, 31); end
        endcase
        if (k <= 6) return r_type(rs, rt, rd, sh, fn);
        if (k == 9) return i_type(OP_LW, 0, rt, 16'(32'h200 + 4 * $urandom_range(0, 63)));
        if (k == 10) return i_type(OP_SW, 0, rt, 16'(32'h200 + 4 * $urandom_range(0, 63)));
        if (k == 11 && i + 1 < nb) begin
            off = $urandom_range(0, (nb - 1 - i) < 2 ? (nb - 1 - i) : 2);
            return i_type(OP_BEQ, $urandom_range(0, 3), $urandom_range(0, 3), 16'(off));
        end
        return i_type(OP_ADDI, $urandom_range(0, 7), rt, 16'($urandom));
    endfunction

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        int          sreg;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input int sreg, input logic [31:0] exp);
        vec_t v;
        v.name = nm; v.ins = ins; v.a = a; v.b = b; v.sreg = sreg; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, stores_before;
        rst = 1'b1;

        add_vec("add",      r_type(1, 2, 3, 0, FN_ADD), 32'd5, 32'hFFFF_FFFD, 3, 32'd2);
        add_vec("add_wrap", r_type(1, 2, 3, 0, FN_ADD), 32'h7FFF_FFFF, 32'd1, 3, 32'h8000_0000);
        add_vec("sub",      r_type(1, 2, 3, 0, FN_SUB), 32'd5, 32'd7, 3, 32'hFFFF_FFFE);
        add_vec("and",      r_type(1, 2, 3, 0, FN_AND), 32'hF0F0_1234, 32'h0FF0_FFFF, 3, 32'h00F0_1234);
        add_vec("or",       r_type(1, 2, 3, 0, FN_OR),  32'hF000_0000, 32'h0000_000F, 3, 32'hF000_000F);
        add_vec("slt_neg",  r_type(1, 2, 3, 0, FN_SLT), 32'hFFFF_FFFD, 32'd5, 3, 32'd1);
        add_vec("slt_pos",  r_type(1, 2, 3, 0, FN_SLT), 32'd5, 32'hFFFF_FFFD, 3, 32'd0);
        add_vec("sll4",     r_type(0, 2, 3, 4, FN_SLL), 32'd0, 32'h0F00_00FF, 3, 32'hF000_0FF0);
        add_vec("srl31",    r_type(0, 2, 3, 31, FN_SRL), 32'd0, 32'h8000_0000, 3, 32'd1);
        add_vec("srl4",     r_type(0, 2, 3, 4, FN_SRL), 32'd0, 32'h8000_0000, 3, 32'h0800_0000);
        add_vec("addi_neg", i_type(OP_ADDI, 1, 3, 16'hFFFF), 32'd0, 32'd0, 3, 32'hFFFF_FFFF);
        add_vec("addi_pos", i_type(OP_ADDI, 1, 3, 16'h7FFF), 32'd1, 32'd0, 3, 32'h0000_8000);
        add_vec("add_r0",   r_type(1, 1, 0, 0, FN_ADD), 32'd5, 32'd0, 0, 32'd0);

        // Reset state and ADDI/ADDI/ADD fetch timing
        begin_load();
        imem[0] = i_type(OP_ADDI, 0, 1, 16'd5);
        imem[1] = i_type(OP_ADDI, 0, 2, 16'hFFFD);
        imem[2] = r_type(1, 2, 3, 0, FN_ADD);
        imem[3] = i_type(OP_SW, 0, 3, 16'h0040);
        im_wait = 0; dm_wait = 0;
        release_rst();
        @(negedge clk);
        chk("rst_im_req", 32'(im_req), 32'd1);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        chk("rst_dm_d", dm_d, 32'h0);
        run_to_halt("seqA", 200);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seqA_fetch_cyc%0d", i), q_at(fetch_cyc, i), 32'(4 * i));
            chk($sformatf("seqA_fetch_addr%0d", i), q_at(fetch_addr, i), 32'(4 * i));
        end
        chk("seqA_r3", mem_rd(16), 32'd2);
        chk("seqA_halt_cyc", 32'(halt_cyc), 32'd18);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (im_req || dm_req || !halted) cnt++;
        end
        chk("halt_absorbing", 32'(cnt), 32'd0);

        // Vector table: operands loaded from RAM, result stored back
        foreach (vecs[v]) begin
            begin_load();
            dinit[0] = vecs[v].a;
            dinit[1] = vecs[v].b;
            imem[0] = i_type(OP_LW, 0, 1, 16'h0000);
            imem[1] = i_type(OP_LW, 0, 2, 16'h0004);
            imem[2] = vecs[v].ins;
            imem[3] = i_type(OP_SW, 0, vecs[v].sreg, 16'h0040);
            release_rst();
            run_to_halt(vecs[v].name, 200);
            chk(vecs[v].name, mem_rd(16), vecs[v].exp);
            chk({vecs[v].name, "_cycles"}, 32'(halt_cyc), 32'd20);
        end

        // SW then LW with two RAM wait states
        begin_load();
        imem[0] = i_type(OP_ADDI, 0, 1, 16'd5);
        imem[1] = i_type(OP_SW, 0, 1, 16'h0008);
        imem[2] = i_type(OP_LW, 0, 4, 16'h0008);
        imem[3] = i_type(OP_SW, 0, 4, 16'h0044);
        dm_wait = 2;
        release_rst();
        run_to_halt("seqB", 300);
        chk("seqB_sw_req_len", q_at(dm_runs, 0), 32'd3);
        chk("seqB_lw_req_len", q_at(dm_runs, 1), 32'd3);
        chk("seqB_sw_addr", q_at(acc_addr, 0), 32'd8);
        chk("seqB_sw_data", q_at(acc_data, 0), 32'd5);
        chk("seqB_lw_addr", q_at(acc_addr, 1), 32'd8);
        chk("seqB_stable", 32'(dm_unstable), 32'd0);
        chk("seqB_lw_cycles", q_at(fetch_cyc, 3) - q_at(fetch_cyc, 2), 32'd7);
        chk("seqB_ram8", mem_rd(2), 32'd5);
        chk("seqB_r4", mem_rd(17), 32'd5);
        chk("seqB_halt_cyc", 32'(halt_cyc), 32'd25);
        dm_wait = 0;

        // Branches, JAL and JR
        begin_load();
        imem[0]  = i_type(OP_ADDI, 0, 1, 16'd5);
        imem[1]  = i_type(OP_ADDI, 0, 2, 16'hFFFD);
        imem[2]  = i_type(OP_ADDI, 0, 3, 16'd1);
        imem[3]  = i_type(OP_ADDI, 0, 3, 16'd1);
        imem[4]  = i_type(OP_BEQ, 1, 1, 16'd2);
        imem[7]  = i_type(OP_BEQ, 1, 2, 16'd2);
        imem[8]  = j_type(OP_JAL, 26'h40);
        imem[9]  = i_type(OP_SW, 0, 31, 16'h0048);
        imem[64] = r_type(31, 0, 0, 0, FN_JR);
        release_rst();
        run_to_halt("seqC", 300);
        begin
            logic [31:0] exp_addr [0:9];
            exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h24, 32'h28};
            for (int i = 4; i < 10; i++)
                chk($sformatf("seqC_fetch_addr%0d", i), q_at(fetch_addr, i), exp_addr[i]);
        end
        chk("seqC_beq_cycles", q_at(fetch_cyc, 5) - q_at(fetch_cyc, 4), 32'd3);
        chk("seqC_jal_cycles", q_at(fetch_cyc, 7) - q_at(fetch_cyc, 6), 32'd2);
        chk("seqC_jr_cycles", q_at(fetch_cyc, 8) - q_at(fetch_cyc, 7), 32'd3);
        chk("seqC_r31", mem_rd(18), 32'h24);
        chk("seqC_fetches", 32'(fetch_addr.size()), 32'd10);

        // Reset pulse during a stalled store
        begin_load();
        imem[0] = i_type(OP_ADDI, 0, 1, 16'd5);
        imem[1] = i_type(OP_SW, 0, 1, 16'h0008);
        dm_wait = 1000;
        release_rst();
        n = 0;
        while (!dm_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("seqF_dm_req_seen", 32'(dm_req), 32'd1);
        repeat (2) @(negedge clk);
        stores_before = n_stores;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("seqF_dm_req", 32'(dm_req), 32'd0);
        chk("seqF_im_req", 32'(im_req), 32'd1);
        chk("seqF_pc", im_addr, 32'h0);
        chk("seqF_dm_addr", 32'(dm_addr), 32'h0);
        chk("seqF_dm_d", dm_d, 32'h0);
        chk("seqF_no_store", 32'(n_stores), 32'(stores_before));
        dm_wait = 0;
        run_to_halt("seqF", 200);
        chk("seqF_refetch", q_at(fetch_addr, 0), 32'h0);
        chk("seqF_ram8", mem_rd(2), 32'd5);
        chk("seqF_halt_cyc", 32'(halt_cyc), 32'd10);

        // Random programs against the instruction-level model
        for (int p = 0; p < 8; p++) begin
            begin_load();
            for (int i = 128; i < 192; i++) dinit[i] = $urandom;
            for (int i = 0; i < 24; i++) imem[i] = rand_instr(i, 24);
            for (int r = 1; r < 8; r++) imem[23 + r] = i_type(OP_SW, 0, r, 16'(32'h300 + 4 * r));
            im_wait = $urandom_range(0, 2);
            dm_wait = $urandom_range(0, 2);
            model_run(im_wait, dm_wait);
            release_rst();
            run_to_halt("rand", 3000);
            chk($sformatf("rand%0d_halt_cyc", p), 32'(halt_cyc), 32'(m_halt_cyc));
            chk($sformatf("rand%0d_fetches", p), 32'(fetch_addr.size()), 32'(m_fetches));
            for (int i = 128; i < 200; i++)
                chk($sformatf("rand%0d_mem%0d", p, i), mem_rd(i), m_mem[i]);
        end

        chk("req_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multi_cycle.md
# mips_multi_cycle

Parametrised multi-cycle MIPS core that succeeds the single-cycle datapath. A one-hot-free binary FSM sequences FETCH/DECODE/EXEC/MEM/WB over one shared ALU. Instruction and data memory are reached through request/ready handshakes, so memories may insert wait states. It sits between the program ROM and the data RAM at the top of the processor and exposes a halt indication for the bench.

## Interface
- N, 32: datapath and register width; must be ≥ 32 for jump-target formation.
- ADDR_W, 16: data-memory address width; DM_ADDR is the low ADDR_W bits of the effective byte address.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- IM_REQ  out  1  instruction fetch request.
- IM_ADDR  out  N  byte address of instruction (= PC).
- IM_RDY  in  1  fetch accepted; INSTRUCTION valid this cycle.
- INSTRUCTION  in  32  instruction word.
- DM_REQ  out  1  data access request.
- DM_WE  out  1  1 = store, 0 = load; valid while DM_REQ.
- DM_ADDR  out  ADDR_W  data byte address.
- DM_D  out  N  store data (rt).
- DM_Q  in  N  load data, valid with DM_RDY.
- DM_RDY  in  1  data access complete.
- HALTED  out  1  core stopped on an illegal instruction.

## Operation
- Register file: 32 × N, r0 reads 0, writes to r0 discarded; two reads in DECODE, one write in WB.
- Supported: R-type (op 0) funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed), SLL 0x00, SRL 0x02 (shamt from [10:6]), JR 0x08; I-type ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04; J 0x02, JAL 0x03 (writes PC+4 to r31). Any other op/funct → HALT.
- Immediates are sign-extended to N. Arithmetic wraps modulo 2^N, no overflow trap.
- PC is a byte address. Sequential next = PC+4. BEQ target = PC+4+(simm<<2). J/JAL target = {PC+4[N-1:28], imm26, 2'b00}. JR target = rs.
- State FETCH: IM_REQ=1, IM_ADDR=PC held stable. On an edge with IM_RDY=1 the core latches IR and goes to DECODE.
- DECODE: latch A=rs and B=rt. J/JAL update PC (JAL also writes r31) and return to FETCH. Illegal instructions go to HALT.
- EXEC: compute the ALU result. BEQ: PC=target if A==B else PC+4, then FETCH. JR: PC=A, then FETCH. LW/SW go to MEM. Others go to WB.
- MEM: DM_REQ=1 with DM_ADDR, DM_WE and DM_D stable until an edge with DM_RDY=1. LW latches DM_Q and goes to WB. SW sets PC+=4 and goes to FETCH.
- WB: write rd (R-type), rt (ADDI/LW); PC+=4; FETCH.
- HALT: absorbing state. HALTED=1, no requests; only rst exits.
- Register and PC updates happen only at the listed transitions, so a stalled handshake changes no architectural state.

## Timing
- Reset: state=FETCH, PC=RESET_PC, all registers 0, IM_REQ=1 on the first cycle after reset. DM_REQ, DM_WE and HALTED are 0, and DM_ADDR and DM_D are 0 on the cycle after rst.
- With zero-wait memories (RDY high in the first request cycle), cycles per instruction are: R-type/ADDI 4, LW 5, SW 4, BEQ/JR 3, J/JAL 2.
- Each wait cycle on IM_RDY/DM_RDY adds exactly one cycle. RDY while REQ=0 is ignored.
- IM_REQ and DM_REQ are never high in the same cycle.
- A write in WB is visible to the DECODE of the next instruction (no forwarding needed).
- rst asserted during any state, including mid-handshake: REQ drops on the next edge and the in-flight access is abandoned without writeback.

## Test plan
- Reset then zero-wait ROM with ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2 -> r3=2, and IM_ADDR sequence 0,4,8 at cycles 0,4,8.
- SW r1,8(r0) then LW r4,8(r0), with RAM inserting 2 wait cycles -> DM_REQ held 3 cycles each with DM_ADDR=8 and DM_D=5 stable; r4=5; LW takes 7 cycles total.
- BEQ r1,r1,+2 at PC 0x10 -> next IM_ADDR=0x1C. BEQ r1,r2 (unequal) -> 0x14.
- JAL 0x40 at PC 0x20 -> r31=0x24 and next IM_ADDR=0x100. JR r31 -> IM_ADDR=0x24.
- SLT r5,r2,r1 with r2=-3, r1=5 -> r5=1. SRL of 0x80000000 by 31 -> 1. ADD r0,r1,r1 -> r0 still 0.
- Illegal op 0x3F -> HALTED=1 and no further IM_REQ. Pulse rst during a stalled DM_REQ -> DM_REQ=0 next cycle, PC=RESET_PC, and the fetch restarts.
